// File: rtl/pipelined_control_unit.sv
// LEGv8 pipelined control: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use stall, branch-taken flush and saturating stall/flush event counters.
module pipelined_control_unit #(
  parameter int unsigned OPCODE_W  = 11,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned ZERO_REG  = 31,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned HAZARD_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                ex_branch_taken,
  output logic                stall,
  output logic                flush_if_id,
  output logic                id_illegal,
  output logic                ex_alusrc,
  output logic                ex_branch,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_regwrite,
  output logic                ex_memtoreg,
  output logic [1:0]          ex_aluop,
  output logic [REG_W-1:0]    ex_rd,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic                mem_regwrite,
  output logic                mem_memtoreg,
  output logic [REG_W-1:0]    mem_rd,
  output logic                wb_regwrite,
  output logic                wb_memtoreg,
  output logic [REG_W-1:0]    wb_rd,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [REG_W-1:0] ZR     = REG_W'(ZERO_REG);
  localparam logic             HAZ_ON = (HAZARD_EN != 0);

  ctrl_t            dec;
  logic             known, rs1_used, rs2_used;
  logic             eff_taken, hazard, bubble;

  ctrl_t            idex_q, idex_d;
  logic [REG_W-1:0] idex_rd_q, idex_rd_d;
  logic             exmem_memread_q, exmem_memwrite_q, exmem_regwrite_q, exmem_memtoreg_q;
  logic [REG_W-1:0] exmem_rd_q;
  logic             memwb_regwrite_q, memwb_memtoreg_q;
  logic [REG_W-1:0] memwb_rd_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    dec      = '0;
    known    = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    casez (id_opcode[10:0])
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        dec      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      11'b1001000100?: begin
        dec      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
        rs1_used = 1'b1;
      end
      11'b11111000010: begin
        dec      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        rs1_used = 1'b1;
      end
      11'b11111000000: begin
        dec      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      11'b10110100???: begin
        dec      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        rs2_used = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // A taken branch in EX squashes whatever sits in ID, so it overrides any stall.
  always_comb begin
    id_illegal  = id_valid & ~known;
    eff_taken   = ex_branch_taken & idex_q.branch;
    hazard      = HAZ_ON & id_valid & idex_q.memread & (idex_rd_q != ZR) &
                  ((rs1_used & (id_rs1 == idex_rd_q)) | (rs2_used & (id_rs2 == idex_rd_q)));
    stall       = hazard & ~eff_taken;
    flush_if_id = eff_taken;
    bubble      = rst | eff_taken | stall | ~id_valid | id_illegal;
    idex_d      = bubble ? '0 : dec;
    idex_rd_d   = bubble ? '0 : id_rd;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (eff_taken && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q           <= '0;
      idex_rd_q        <= '0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_regwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
      memwb_memtoreg_q <= 1'b0;
      memwb_rd_q       <= '0;
      stall_cnt_q      <= '0;
      flush_cnt_q      <= '0;
    end else begin
      idex_q           <= idex_d;
      idex_rd_q        <= idex_rd_d;
      exmem_memread_q  <= idex_q.memread;
      exmem_memwrite_q <= idex_q.memwrite;
      exmem_regwrite_q <= idex_q.regwrite;
      exmem_memtoreg_q <= idex_q.memtoreg;
      exmem_rd_q       <= idex_rd_q;
      memwb_regwrite_q <= exmem_regwrite_q;
      memwb_memtoreg_q <= exmem_memtoreg_q;
      memwb_rd_q       <= exmem_rd_q;
      stall_cnt_q      <= stall_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
    end
  end

  assign ex_alusrc    = idex_q.alusrc;
  assign ex_branch    = idex_q.branch;
  assign ex_memread   = idex_q.memread;
  assign ex_memwrite  = idex_q.memwrite;
  assign ex_regwrite  = idex_q.regwrite;
  assign ex_memtoreg  = idex_q.memtoreg;
  assign ex_aluop     = idex_q.aluop;
  assign ex_rd        = idex_rd_q;
  assign mem_memread  = exmem_memread_q;
  assign mem_memwrite = exmem_memwrite_q;
  assign mem_regwrite = exmem_regwrite_q;
  assign mem_memtoreg = exmem_memtoreg_q;
  assign mem_rd       = exmem_rd_q;
  assign wb_regwrite  = memwb_regwrite_q;
  assign wb_memtoreg  = memwb_memtoreg_q;
  assign wb_rd        = memwb_rd_q;
  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed table-driven bench for pipelined_control_unit (2-bit counters to reach saturation).
module tb_pipelined_control_unit;

  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [10:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_branch_taken;
  logic stall, flush_if_id, id_illegal;
  logic ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
  logic wb_regwrite, wb_memtoreg;
  logic [CW-1:0] stall_count, flush_count;

  pipelined_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush_if_id(flush_if_id), .id_illegal(id_illegal),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001, OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000, OP_CBZ = 11'b10110100101;
  // {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}
  localparam logic [7:0] C_R = 8'b0010_0010, C_ADDI = 8'b1010_0011, C_LD = 8'b1111_0000;
  localparam logic [7:0] C_ST = 8'b1000_1000, C_CBZ = 8'b0000_0101, C_NOP = 8'b0000_0000;

  typedef struct {
    logic        v;
    logic [10:0] op;
    logic [4:0]  rs1, rs2, rd;
    logic        bt;
    logic        e_stall, e_flush, e_ill;
    logic [7:0]  e_ctrl;
    logic [4:0]  e_rd;
    int          e_sc, e_fc;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] p1_c, p2_c;
  logic [4:0] p1_rd, p2_rd;

  function automatic vec_t mk(logic v, logic [10:0] op, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic bt, logic es, logic ef, logic ei,
                              logic [7:0] ec, logic [4:0] erd, int sc, int fc);
    vec_t t;
    t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.bt = bt;
    t.e_stall = es; t.e_flush = ef; t.e_ill = ei; t.e_ctrl = ec; t.e_rd = erd;
    t.e_sc = sc; t.e_fc = fc;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [10:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] d, input logic bt);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = d; ex_branch_taken = bt;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ex"}, 0, {24'd0, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                          ex_memwrite, ex_branch, ex_aluop}, 32'd0);
    chk({tag, "_ex_rd"}, 0, {27'd0, ex_rd}, 32'd0);
    chk({tag, "_mem"}, 0, {23'd0, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd}, 32'd0);
    chk({tag, "_wb"}, 0, {25'd0, wb_regwrite, wb_memtoreg, wb_rd}, 32'd0);
    chk({tag, "_cnt"}, 0, {28'd0, stall_count, flush_count}, 32'd0);
  endtask

  initial begin
    // Stall steps: 5,10,17,25,27 (saturates at 3). Flush steps: 15,19.
    tbl.push_back(mk(1, OP_LDUR, 1, 0, 3, 0, 0, 0, 0, C_LD,   3, 0, 0)); // 1
    tbl.push_back(mk(1, OP_ADD,  2, 4, 6, 0, 0, 0, 0, C_R,    6, 0, 0)); // 2
    tbl.push_back(mk(1, OP_ORR,  0, 0, 1, 0, 0, 0, 0, C_R,    1, 0, 0)); // 3
    tbl.push_back(mk(1, OP_LDUR, 2, 0, 5, 0, 0, 0, 0, C_LD,   5, 0, 0)); // 4
    tbl.push_back(mk(1, OP_ADD,  5, 0, 7, 0, 1, 0, 0, C_NOP,  0, 1, 0)); // 5 load-use on rs1
    tbl.push_back(mk(1, OP_ADD,  5, 0, 7, 0, 0, 0, 0, C_R,    7, 1, 0)); // 6 ADD issues
    tbl.push_back(mk(1, OP_LDUR, 0, 0, 31, 0, 0, 0, 0, C_LD, 31, 1, 0)); // 7
    tbl.push_back(mk(1, OP_SUB, 31, 31, 2, 0, 0, 0, 0, C_R,   2, 1, 0)); // 8 XZR never hazards
    tbl.push_back(mk(1, OP_LDUR, 1, 0, 7, 0, 0, 0, 0, C_LD,   7, 1, 0)); // 9
    tbl.push_back(mk(1, OP_STUR, 1, 7, 0, 0, 1, 0, 0, C_NOP,  0, 2, 0)); // 10 STUR rs2 hazard
    tbl.push_back(mk(1, OP_STUR, 1, 7, 0, 0, 0, 0, 0, C_ST,   0, 2, 0)); // 11
    tbl.push_back(mk(1, OP_LDUR, 1, 0, 7, 0, 0, 0, 0, C_LD,   7, 2, 0)); // 12
    tbl.push_back(mk(1, OP_ADDI, 2, 7, 9, 0, 0, 0, 0, C_ADDI, 9, 2, 0)); // 13 rs2 unused
    tbl.push_back(mk(1, OP_CBZ,  7, 1, 0, 0, 0, 0, 0, C_CBZ,  0, 2, 0)); // 14
    tbl.push_back(mk(1, OP_ADD,  1, 2, 3, 1, 0, 1, 0, C_NOP,  0, 2, 1)); // 15 taken -> flush
    tbl.push_back(mk(1, OP_LDUR, 1, 0, 4, 0, 0, 0, 0, C_LD,   4, 2, 1)); // 16
    tbl.push_back(mk(1, OP_CBZ,  0, 4, 0, 0, 1, 0, 0, C_NOP,  0, 3, 1)); // 17 CBZ rs2 hazard
    tbl.push_back(mk(1, OP_CBZ,  0, 4, 0, 0, 0, 0, 0, C_CBZ,  0, 3, 1)); // 18
    tbl.push_back(mk(1, OP_ADD,  1, 2, 3, 1, 0, 1, 0, C_NOP,  0, 3, 2)); // 19 flush
    tbl.push_back(mk(1, OP_AND,  1, 2, 3, 1, 0, 0, 0, C_R,    3, 3, 2)); // 20 taken but no branch in EX
    tbl.push_back(mk(1, 11'd0,   0, 0, 5, 0, 0, 0, 1, C_NOP,  0, 3, 2)); // 21 illegal
    tbl.push_back(mk(0, OP_ADD,  0, 0, 5, 0, 0, 0, 0, C_NOP,  0, 3, 2)); // 22 invalid
    tbl.push_back(mk(0, 11'd0,   0, 0, 5, 0, 0, 0, 0, C_NOP,  0, 3, 2)); // 23 invalid, undecodable
    tbl.push_back(mk(1, OP_LDUR, 0, 0, 8, 0, 0, 0, 0, C_LD,   8, 3, 2)); // 24
    tbl.push_back(mk(1, OP_ADD,  8, 0, 1, 0, 1, 0, 0, C_NOP,  0, 3, 2)); // 25 saturated
    tbl.push_back(mk(1, OP_LDUR, 0, 0, 8, 0, 0, 0, 0, C_LD,   8, 3, 2)); // 26
    tbl.push_back(mk(1, OP_SUB,  0, 8, 1, 0, 1, 0, 0, C_NOP,  0, 3, 2)); // 27 saturated

    rst = 1'b1;
    drive(0, 11'd0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("reset");
    chk("reset_comb", 0, {29'd0, stall, flush_if_id, id_illegal}, 32'd0);

    p1_c = '0; p2_c = '0; p1_rd = '0; p2_rd = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].bt);
      #1;
      chk("stall", i + 1, {31'd0, stall}, {31'd0, tbl[i].e_stall});
      chk("flush", i + 1, {31'd0, flush_if_id}, {31'd0, tbl[i].e_flush});
      chk("illegal", i + 1, {31'd0, id_illegal}, {31'd0, tbl[i].e_ill});
      @(posedge clk); #1;
      chk("ex_ctrl", i + 1, {24'd0, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                             ex_memwrite, ex_branch, ex_aluop}, {24'd0, tbl[i].e_ctrl});
      chk("ex_rd", i + 1, {27'd0, ex_rd}, {27'd0, tbl[i].e_rd});
      chk("mem", i + 1, {23'd0, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd},
          {23'd0, p1_c[4], p1_c[3], p1_c[5], p1_c[6], p1_rd});
      chk("wb", i + 1, {25'd0, wb_regwrite, wb_memtoreg, wb_rd}, {25'd0, p2_c[5], p2_c[6], p2_rd});
      chk("stall_count", i + 1, {30'd0, stall_count}, tbl[i].e_sc);
      chk("flush_count", i + 1, {30'd0, flush_count}, tbl[i].e_fc);
      p2_c = p1_c; p2_rd = p1_rd;
      p1_c = tbl[i].e_ctrl; p1_rd = tbl[i].e_rd;
    end

    // Fill all three stages, then reset mid-pipeline with a valid load in ID.
    drive(1, OP_LDUR, 0, 0, 10, 0); @(posedge clk); #1;
    drive(1, OP_ADD, 1, 2, 11, 0);  @(posedge clk); #1;
    drive(1, OP_STUR, 1, 2, 12, 0); @(posedge clk); #1;
    chk("full_wb_rd", 100, {27'd0, wb_rd}, 32'd10);
    chk("full_mem_rd", 100, {27'd0, mem_rd}, 32'd11);
    chk("full_ex_memwrite", 100, {31'd0, ex_memwrite}, 32'd1);
    drive(1, OP_LDUR, 0, 0, 13, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 11'd0, 0, 0, 0, 0);
    check_all_zero("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation LEGv8 control block: decodes the 11-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards (stall) and applies branch-taken flushes (bubble insertion).
- Counts stall and flush events.
- Sits between the IF/ID register and the datapath; replaces the single-cycle combinational control unit.

Parameters:
- OPCODE_W, 11, opcode field width
- REG_W, 5, register address width
- ZERO_REG, 31, XZR index; never a hazard source
- CNT_W, 16, width of the saturating event counters
- HAZARD_EN, 1, 1 = load-use detection active; 0 = stall held at 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  OPCODE_W  instruction[31:21]
- id_rs1  in  REG_W  Rn
- id_rs2  in  REG_W  Rm for R-type; Rt for STUR/CBZ
- id_rd  in  REG_W  destination (Rd/Rt)
- ex_branch_taken  in  1  EX branch condition true (zero flag)
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  clear IF/ID
- id_illegal  out  1  valid, undecodable opcode
- ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  out  1 each  ID/EX controls
- ex_aluop  out  2  ID/EX ALUOp
- ex_rd  out  REG_W  ID/EX destination
- mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out  1 each  EX/MEM controls
- mem_rd  out  REG_W  EX/MEM destination
- wb_regwrite, wb_memtoreg  out  1 each  MEM/WB controls
- wb_rd  out  REG_W  MEM/WB destination
- stall_count, flush_count  out  CNT_W  saturating event counters

Behaviour:
- Decode (combinational, ID), fields ALUSrc/MemToReg/RegWrite/MemRead/MemWrite/Branch/ALUOp:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> 0/0/1/0/0/0/10
  - ADDI 1001000100x -> 1/0/1/0/0/0/11
  - LDUR 11111000010 -> 1/1/1/1/0/0/00
  - STUR 11111000000 -> 1/0/0/0/1/0/00
  - CBZ 10110100xxx -> 0/0/0/0/0/1/01
  - Any other opcode -> all zero; id_illegal = id_valid.
- Source usage:
  - rs1_used for R-type, ADDI, LDUR, STUR.
  - rs2_used for R-type, STUR, CBZ.
- eff_taken = ex_branch_taken & ex_branch. ex_branch_taken is ignored when ex_branch = 0.
- Load-use hazard = HAZARD_EN & id_valid & ex_memread & (ex_rd != ZERO_REG) & ((rs1_used & id_rs1 == ex_rd) | (rs2_used & id_rs2 == ex_rd)).
- Combinational outputs:
  - stall = hazard & ~eff_taken.
  - flush_if_id = eff_taken.
  - Flush has priority over stall.
- ID/EX update each clock:
  - Loads a bubble (all controls 0, rd 0) if rst | eff_taken | stall | ~id_valid | id_illegal.
  - Otherwise loads the decoded bundle and id_rd.
- EX/MEM and MEM/WB advance unconditionally every clock: EX/MEM <= ID/EX subset, MEM/WB <= EX/MEM subset. Neither is affected by stall or flush.
- Latency: an instruction decoded at edge N appears on ex_* after N, mem_* after N+1, wb_* after N+2.
- Counters:
  - stall_count increments on each clock with stall = 1.
  - flush_count increments on each clock with eff_taken = 1.
  - Both saturate at 2^CNT_W - 1; no wrap.
- Reset: every registered output (all ex_*, mem_*, wb_* signals and both counters) is 0 on the clock after rst is sampled high. stall, flush_if_id and id_illegal follow their combinational equations from the reset state, so they are 0 unless id_* inputs force id_illegal.
- Mid-pipeline reset clears all stages in the same edge; no partial drain.
- Back-to-back stalls: a stall persists while the hazard holds; it cannot exceed 1 cycle per load because the bubble clears ex_memread.

Test Plan:
- Reset/decode: rst 1 cycle, then LDUR (11111000010, rd=3) -> one edge later ex_alusrc=1, ex_memtoreg=1, ex_regwrite=1, ex_memread=1, ex_aluop=00, ex_rd=3; two edges later mem_memread=1; three edges later wb_memtoreg=1, wb_rd=3.
- Load-use: LDUR rd=5, then ADD rs1=5 -> stall=1 for exactly 1 cycle, ID/EX holds a bubble, ADD issues the next cycle, stall_count=1. Repeat with rd=31 -> stall never asserts.
- STUR/CBZ rs2 path: LDUR rd=7 then STUR rs2=7 -> stall=1. LDUR rd=7 then ADDI rs2=7 (unused) -> stall=0.
- Branch flush: CBZ in EX with ex_branch_taken=1 -> flush_if_id=1, next ID/EX is a bubble, flush_count=1. Same cycle with a load-use hazard present -> stall=0. ex_branch_taken=1 with a non-branch in EX -> no flush.
- Illegal/invalid: opcode 00000000000 with id_valid=1 -> id_illegal=1 and a bubble inserted; id_valid=0 -> id_illegal=0 and a bubble inserted.
- Saturation/reset: CNT_W=2, 5 stalls -> stall_count=3. Assert rst with all stages full -> every ex_*/mem_*/wb_* output and both counters read 0 the next cycle.
